// File: rtl/crc_table_pkg.sv
// Shared types and helpers for the CRC lookup-table generator.
// Holds the build FSM state type, a width-generic bit reverse and common polynomials.
package crc_table_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StWrite,
        StFin
    } state_e;

    localparam logic [31:0] PolyCrc32      = 32'h04C11DB7;
    localparam logic [15:0] PolyCrc16Ccitt = 16'h1021;
    localparam logic [31:0] PolyCrc32c     = 32'h1EDC6F41;

    // Reverses the low `width` bits of v; bits at and above `width` come back zero.
    function automatic logic [63:0] bitrev(input logic [63:0] v, input int unsigned width);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i < width) begin
                r[i] = v[width - 1 - i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_table_step.sv
// One bit step of a CRC shift register, MSB-first or reflected (LSB-first).
module crc_table_step
    import crc_table_pkg::*;
#(
    parameter int unsigned          CRC_WIDTH = 32,
    parameter logic [CRC_WIDTH-1:0] POLY      = CRC_WIDTH'(PolyCrc32),
    parameter bit                   REFLECT   = 1'b0
) (
    input  logic [CRC_WIDTH-1:0] v_i,
    output logic [CRC_WIDTH-1:0] v_next_o
);

    localparam logic [63:0]          PolyRevWide = bitrev(64'(POLY), CRC_WIDTH);
    localparam logic [CRC_WIDTH-1:0] PolyRev     = PolyRevWide[CRC_WIDTH-1:0];

    always_comb begin
        v_next_o = '0;
        if (REFLECT) begin
            v_next_o = (v_i >> 1) ^ (v_i[0] ? PolyRev : '0);
        end else begin
            v_next_o = (v_i << 1) ^ (v_i[CRC_WIDTH-1] ? POLY : '0);
        end
    end

endmodule

// File: rtl/crc_table_gen.sv
// Builds every CRC table entry bit-serially and streams (addr, data) pairs
// to a table RAM over a valid/ready write port.
module crc_table_gen
    import crc_table_pkg::*;
#(
    parameter int unsigned          CRC_WIDTH  = 32,
    parameter int unsigned          ADDR_WIDTH = 8,
    parameter logic [CRC_WIDTH-1:0] POLY       = CRC_WIDTH'(PolyCrc32),
    parameter bit                   REFLECT    = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  ABORT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  WR_EN,
    input  logic                  WR_RDY,
    output logic [ADDR_WIDTH-1:0] WR_ADDR,
    output logic [CRC_WIDTH-1:0]  WR_DATA
);

    localparam int unsigned           CntWidth = $clog2(ADDR_WIDTH + 1);
    localparam logic [CntWidth-1:0]   LastStep = CntWidth'(ADDR_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CRC_WIDTH-1:0]  crc_q, crc_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [CRC_WIDTH-1:0]  crc_step;
    logic [ADDR_WIDTH-1:0] addr_inc;

    // Message bits must enter at the end the step shifts out of.
    function automatic logic [CRC_WIDTH-1:0] seed(input logic [ADDR_WIDTH-1:0] a);
        if (REFLECT) begin
            return CRC_WIDTH'(a);
        end
        return CRC_WIDTH'(a) << (CRC_WIDTH - ADDR_WIDTH);
    endfunction

    crc_table_step #(
        .CRC_WIDTH(CRC_WIDTH),
        .POLY     (POLY),
        .REFLECT  (REFLECT)
    ) u_step (
        .v_i     (crc_q),
        .v_next_o(crc_step)
    );

    assign addr_inc = addr_q + 1'b1;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (START) begin
                    addr_d  = '0;
                    crc_d   = seed('0);
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                crc_d = crc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastStep) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (WR_RDY) begin
                    if (addr_q == LastAddr) begin
                        state_d = StFin;
                    end else begin
                        addr_d  = addr_inc;
                        crc_d   = seed(addr_inc);
                        cnt_d   = '0;
                        state_d = StCalc;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Abort overrides the next state only; a handshake on the same edge still lands.
        if (ABORT && (state_q != StIdle)) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            addr_q  <= '0;
            crc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign BUSY    = (state_q != StIdle);
    assign DONE    = (state_q == StFin);
    assign WR_EN   = (state_q == StWrite);
    assign WR_ADDR = addr_q;
    assign WR_DATA = crc_q;

endmodule

// File: doc/crc_table_gen.md
Name: crc_table_gen

Overview:
- Runtime generator for CRC lookup-table contents.
- Computes entry[a] = CRC of the ADDR_WIDTH-bit message a (zero init, no final XOR) for every address and streams each (addr, data) pair out of a valid/ready write port.
- Writes into a writable table RAM that the CRC datapath reads through its lookup ports.
- Replaces file preload when POLY or REFLECT must be chosen at elaboration time or the table must be rebuilt at run time.

Parameters:
- CRC_WIDTH, 32, table entry width in bits; legal range 8..64.
- ADDR_WIDTH, 8, message chunk width; the table has 2^ADDR_WIDTH entries; must be ≤ CRC_WIDTH.
- POLY, 32'h04C11DB7, generator polynomial in normal (MSB-first) form, implicit x^CRC_WIDTH term; width CRC_WIDTH.
- REFLECT, 0, 0 = MSB-first table; 1 = LSB-first (reflected) table using bit-reversed POLY.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous active-high reset.
- START  in  1  begin a full table build; sampled only in IDLE.
- ABORT  in  1  cancel the build in progress.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse after the last entry is accepted.
- WR_EN  out  1  write valid.
- WR_RDY  in  1  write ready from the table RAM.
- WR_ADDR  out  ADDR_WIDTH  entry index.
- WR_DATA  out  CRC_WIDTH  entry value.

Behaviour:
- Reset (RST=1 at an edge): state IDLE; BUSY=0, DONE=0, WR_EN=0, WR_ADDR=0, WR_DATA=0, bit counter=0.
- Reset mid-build: same; entries already written stay in the RAM; no DONE.
- States: IDLE, CALC, WRITE, FIN.
- IDLE: on START=1, load addr=0, load seed, counter=0, go to CALC. START is ignored in every other state.
- Seed, REFLECT=0: addr << (CRC_WIDTH-ADDR_WIDTH).
- Seed, REFLECT=1: addr zero-extended.
- CALC: one bit step per edge; counter increments; after ADDR_WIDTH steps, go to WRITE.
- Step, REFLECT=0: msb = v[CRC_WIDTH-1]; v = v << 1; if msb, v ^= POLY.
- Step, REFLECT=1: lsb = v[0]; v = v >> 1; if lsb, v ^= bitrev(POLY).
- All arithmetic is modulo CRC_WIDTH bits; no carries.
- WRITE: WR_EN=1, with WR_ADDR=addr and WR_DATA=v. WR_ADDR and WR_DATA are held stable while WR_RDY=0 (no dropping, no changing).
- WRITE handshake (WR_EN & WR_RDY at an edge):
  - If addr = 2^ADDR_WIDTH-1, go to FIN.
  - Otherwise addr += 1, reseed, counter=0, go to CALC.
- WR_RDY is ignored whenever WR_EN=0.
- FIN: DONE=1 for exactly one cycle, then IDLE. WR_EN=0.
- ABORT=1 in CALC, WRITE or FIN: go to IDLE at that edge, WR_EN drops next cycle, no DONE.
  - ABORT together with a WRITE handshake: the handshake still counts (that entry is written), then IDLE.
  - ABORT in IDLE: no effect.
  - ABORT and START both high in IDLE: start is taken.
- RST has priority over ABORT, and ABORT over normal transitions.
- Timing with WR_RDY held at 1:
  - START sampled at edge 0, so WR_EN is first high after edge ADDR_WIDTH.
  - Handshakes are spaced ADDR_WIDTH+1 cycles apart.
  - The last handshake occurs at edge 2^ADDR_WIDTH·(ADDR_WIDTH+1); DONE is high in the following cycle.
- Address wrap: the address never wraps; FIN is entered instead.

Decomposition:
- Shared package crc_table_pkg:
  - state enum (IDLE, CALC, WRITE, FIN)
  - bit-reverse function, parameterised by width
  - named polynomial constants: CRC32 04C11DB7, CRC16_CCITT 1021, CRC32C 1EDC6F41
- One combinational sub-module, crc_table_step: one bit step with inputs v and REFLECT/POLY parameters and output v_next.
  - Also usable later for a multi-bit-per-cycle variant.

Test Plan:
- CRC_WIDTH=32, POLY=04C11DB7, REFLECT=0, WR_RDY=1, pulse START -> WR_ADDR 1 carries 04C11DB7, addr 2 carries 09823B6E, addr 255 carries B1F740B4; first WR_EN 8 cycles after START edge; DONE exactly 2304 edges after START edge.
- Same POLY, REFLECT=1 -> addr 1 = 77073096, addr 128 = EDB88320, addr 255 = 2D02EF8D; addr 0 = 00000000.
- CRC_WIDTH=16, POLY=1021, REFLECT=0 -> addr 1 = 1021, addr 255 = 1EF0; 256 writes, one DONE pulse.
- Random WR_RDY stalls (≥10 consecutive low cycles) -> WR_ADDR and WR_DATA stable while stalled; each address 0..255 written exactly once, in order.
- ABORT during WRITE of addr 37 with WR_RDY=0 -> no write of 37, WR_EN low next cycle, BUSY low, no DONE; a new START rebuilds from addr 0.
- RST asserted in CALC mid-build, and START asserted while BUSY -> RST gives all outputs 0 next cycle; START while BUSY is ignored (no restart, address sequence unaffected).
